fir_decimator: RTL and testbench
================================

FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 Parameter IW, default 16, sample width (signed two's complement).
REQ-002 Parameter CW, default 16, coefficient width (signed, Q1.(CW-1)).
REQ-003 Parameter TAPS, default 32, filter length; legal range >=2.
REQ-004 Parameter CHANNELS, default 2, independent channels sharing one coefficient set; legal range >=1.
REQ-005 Parameter DECIM, default 6, decimation factor; legal range >=1.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 coefficients  in  CW x TAPS  signed coefficient array; index 0 multiplies the newest sample.
REQ-009 in_valid  in  1  in_data holds a sample frame.
REQ-010 in_ready  out  1  block can accept a frame.
REQ-011 in_data  in  IW x CHANNELS  one signed sample per channel.
REQ-012 out_valid  out  1  one-cycle pulse; out_data is new.
REQ-013 out_data  out  IW x CHANNELS  filtered, decimated samples; held between pulses.

Function
REQ-014 A frame SHALL transfer only on a cycle with in_valid=1 and in_ready=1.
REQ-015 Each transfer SHALL write every channel's sample into that channel's circular delay line (depth TAPS) at the write pointer, then advance the pointer, wrapping TAPS-1 -> 0.
REQ-016 A decimation counter SHALL count transfers 0..DECIM-1; the transfer taking it to DECIM-1 (the trigger) SHALL wrap it to 0 and start a computation pass.
REQ-017 FSM states IDLE, MAC, ROUND, OUT; IDLE->MAC on trigger, MAC->ROUND after CHANNELS*TAPS cycles, ROUND->OUT after 1 cycle, OUT->IDLE after 1 cycle.
REQ-018 in_ready SHALL be 1 exactly in IDLE; non-trigger transfers keep the FSM in IDLE.
REQ-019 MAC SHALL perform one multiply-accumulate per cycle, iterating taps 0..TAPS-1 within channel 0, then channel 1, etc.
REQ-020 Per channel, y = sum over i of coefficients[i] * x[n-i], x[n] = trigger-frame sample; full-precision signed accumulation, width IW+CW+clog2(TAPS), no intermediate overflow.
REQ-021 ROUND SHALL add 2^(CW-2), arithmetic-shift right by CW-1, then saturate to [-2^(IW-1), 2^(IW-1)-1].
REQ-022 out_data SHALL update and out_valid SHALL be 1 in OUT only; latency from trigger transfer to out_valid = CHANNELS*TAPS+2 cycles.
REQ-023 DECIM=1: every transfer is a trigger.
REQ-024 coefficients SHALL be read live; the user holds them stable outside IDLE; a change mid-pass gives an unspecified out_data for that pass only.
REQ-025 in_valid while in_ready=0 SHALL be ignored; no frame is stored or counted.

Reset
REQ-026 reset SHALL clear all delay-line entries, write pointer, decimation counter, accumulator and out_data to 0, set out_valid=0, and force IDLE (in_ready=1 on the first cycle after reset).
REQ-027 reset asserted mid-pass SHALL abort it; no out_valid for the aborted pass.
REQ-028 reset SHALL take priority over a simultaneous transfer, which is discarded.

Structure
REQ-029 Package fir_pkg SHALL hold the FSM state typedef and an accumulator-width function of IW, CW and TAPS.
REQ-030 Sub-module fir_mac SHALL contain the multiplier, accumulator (clear/enable), round and saturate; delay lines, pointers, counter and FSM stay in fir_decimator.
REQ-031 Delay lines SHALL be registers, not inferred RAM, so reset clears them in one cycle.

Verification
REQ-032 Impulse: TAPS=8, DECIM=1, CHANNELS=1, coefficients[i]=1024*i; input 16384 then seven 0s -> out_data k = 512*k, k=0..7.
REQ-033 Saturation: all coefficients 32767, constant 32767 -> settled out 32767; constant -32768 -> settled out -32768.
REQ-034 Decimation: DECIM=4, in_valid held 1, ramp input 0,1,2,... -> out_valid once per 4 transfers, first CHANNELS*TAPS+2 cycles after 4th transfer; no transfer while in_ready=0.
REQ-035 Channel isolation: CHANNELS=2, ch0 impulse 16384, ch1 all 0 -> ch1 outputs 0, ch0 matches REQ-032.
REQ-036 Reset mid-MAC: reset at pass cycle 5 -> out_valid stays 0, next cycle in_ready=1; subsequent impulse reproduces REQ-032 with no residue.
REQ-037 Rounding: single coefficient -1, input 1 -> out 0; coefficient 16384, input 3 -> out 2.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the polyphase-free FIR decimator.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Accumulator wide enough for TAPS full-precision products without overflow.
  function automatic int acc_width(input int iw, input int cw, input int taps);
    return iw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Single multiply-accumulate lane with Q1.(CW-1) rounding and output saturation.
module fir_mac #(
  parameter int IW = 16,
  parameter int CW = 16,
  parameter int AW = 37
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [IW-1:0] sample,
  input  logic signed [CW-1:0] coef,
  output logic signed [IW-1:0] result
);

  localparam logic signed [AW:0] RND  = (AW+1)'(1) << (CW - 2);
  localparam logic signed [AW:0] MAXV = (AW+1)'({(IW-1){1'b1}});
  localparam logic signed [AW:0] MINV = ~MAXV;

  logic signed [IW+CW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [AW:0]      rounded;

  assign prod     = sample * coef;
  assign prod_ext = AW'(prod);

  // clr restarts the sum with the current product rather than zero.
  always_comb begin
    acc_d = clr ? '0 : acc_q;
    if (en) acc_d = acc_d + prod_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign rounded = ($signed({acc_q[AW-1], acc_q}) + RND) >>> (CW - 1);

  always_comb begin
    if (rounded > MAXV)      result = MAXV[IW-1:0];
    else if (rounded < MINV) result = MINV[IW-1:0];
    else                     result = rounded[IW-1:0];
  end

endmodule

// File: rtl/fir_decimator.sv
// Multi-channel FIR decimator: register delay lines, decimation counter and a
// sequencer that time-shares one MAC lane across all taps and channels.
//   state | meaning
//   IDLE  | accepting frames, waiting for the decimation trigger
//   MAC   | one tap per cycle, channel 0 first
//   ROUND | last channel's sum rounded and saturated
//   OUT   | out_data new, out_valid high
module fir_decimator
  import fir_pkg::*;
#(
  parameter int IW       = 16,
  parameter int CW       = 16,
  parameter int TAPS     = 32,
  parameter int CHANNELS = 2,
  parameter int DECIM    = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [TAPS-1:0][CW-1:0]     coefficients,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHANNELS-1:0][IW-1:0] in_data,
  output logic                        out_valid,
  output logic [CHANNELS-1:0][IW-1:0] out_data
);

  localparam int AW  = acc_width(IW, CW, TAPS);
  localparam int PW  = $clog2(TAPS);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW  = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_t                      state_q, state_d;
  logic [IW-1:0]               dl_q [CHANNELS][TAPS];
  logic [IW-1:0]               dl_d [CHANNELS][TAPS];
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, tap_q, tap_d, rd_idx;
  logic [PW:0]                 rd_sum;
  logic [CHW-1:0]              ch_q, ch_d;
  logic [DW-1:0]               dcnt_q, dcnt_d;
  logic [CHANNELS-1:0][IW-1:0] res_q, res_d, out_data_q, out_data_d;
  logic                        xfer, trigger, last_mac, mac_clr, mac_en;
  logic [IW-1:0]               mac_result;

  assign xfer     = in_valid && in_ready;
  assign trigger  = xfer && (dcnt_q == DW'(DECIM - 1));
  assign last_mac = (ch_q == CHW'(CHANNELS - 1)) && (tap_q == PW'(TAPS - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = MAC;
      MAC:     if (last_mac) state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    mac_en    = (state_q == MAC);
    mac_clr   = mac_en && (tap_q == '0);
  end

  always_comb begin
    dl_d     = dl_q;
    wr_ptr_d = wr_ptr_q;
    dcnt_d   = dcnt_q;
    if (xfer) begin
      for (int c = 0; c < CHANNELS; c++) dl_d[c][wr_ptr_q] = in_data[c];
      wr_ptr_d = (wr_ptr_q == PW'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
      dcnt_d   = trigger ? '0 : dcnt_q + 1'b1;
    end
  end

  // Newest sample sits just behind the write pointer; tap i reaches i frames back.
  assign rd_sum = {1'b0, wr_ptr_q} + (PW+1)'(TAPS - 1) - {1'b0, tap_q};
  assign rd_idx = (rd_sum >= (PW+1)'(TAPS)) ? PW'(rd_sum - (PW+1)'(TAPS)) : PW'(rd_sum);

  // A channel's finished sum is visible while the next channel loads its first tap.
  always_comb begin
    tap_d      = '0;
    ch_d       = '0;
    res_d      = res_q;
    out_data_d = out_data_q;
    if (state_q == MAC && !last_mac) begin
      if (tap_q == PW'(TAPS - 1)) begin
        ch_d = ch_q + 1'b1;
      end else begin
        tap_d = tap_q + 1'b1;
        ch_d  = ch_q;
      end
    end
    if (mac_clr && ch_q != '0) res_d[ch_q - 1'b1] = mac_result;
    if (state_q == ROUND) begin
      out_data_d             = res_q;
      out_data_d[CHANNELS-1] = mac_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++) dl_q[c][t] <= '0;
      wr_ptr_q   <= '0;
      dcnt_q     <= '0;
      tap_q      <= '0;
      ch_q       <= '0;
      res_q      <= '0;
      out_data_q <= '0;
    end else begin
      dl_q       <= dl_d;
      wr_ptr_q   <= wr_ptr_d;
      dcnt_q     <= dcnt_d;
      tap_q      <= tap_d;
      ch_q       <= ch_d;
      res_q      <= res_d;
      out_data_q <= out_data_d;
    end
  end

  fir_mac #(
    .IW(IW),
    .CW(CW),
    .AW(AW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .sample(dl_q[ch_q][rd_idx]),
    .coef  (coefficients[tap_q]),
    .result(mac_result)
  );

  assign out_data = out_data_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator: a shift-history reference model predicts
// each decimated output frame and its arrival cycle; a monitor checks them.
module tb_fir_decimator;

  localparam int IW    = 16;
  localparam int CW    = 16;
  localparam int TAPS  = 8;
  localparam int CH    = 2;
  localparam int DECIM = 4;
  localparam int N     = CH * TAPS;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [TAPS-1:0][CW-1:0] coefficients;
  logic                  in_valid;
  logic                  in_ready;
  logic [CH-1:0][IW-1:0] in_data;
  logic                  out_valid;
  logic [CH-1:0][IW-1:0] out_data;

  fir_decimator #(
    .IW(IW), .CW(CW), .TAPS(TAPS), .CHANNELS(CH), .DECIM(DECIM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .coefficients(coefficients),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                    due;
    logic [CH-1:0][IW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   hist [CH][TAPS];
  int   cnt;
  int   ready_from;
  int   checks   = 0;
  int   failures = 0;
  bit   last_xfer;

  function automatic logic [IW-1:0] ref_out(input int c);
    longint acc;
    longint lo;
    longint hi;
    acc = 0;
    for (int i = 0; i < TAPS; i++)
      acc += longint'($signed(coefficients[i])) * longint'(hist[c][i]);
    acc = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
    hi  = (longint'(1) << (IW - 1)) - 1;
    lo  = -(longint'(1) << (IW - 1));
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    return acc[IW-1:0];
  endfunction

  task automatic step(input bit v, input logic [IW-1:0] d0, input logic [IW-1:0] d1);
    bit   rdy;
    exp_t e;
    @(negedge clk);
    rdy = (cyc >= ready_from);
    checks++;
    if (in_ready !== rdy) begin
      failures++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, rdy);
    end
    in_valid   = v;
    in_data[0] = d0;
    in_data[1] = d1;
    last_xfer  = v && rdy;
    if (last_xfer) begin
      for (int c = 0; c < CH; c++) begin
        for (int i = TAPS - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
        hist[c][0] = (c == 0) ? int'($signed(d0)) : int'($signed(d1));
      end
      if (cnt == DECIM - 1) begin
        cnt   = 0;
        e.due = cyc + N + 2;
        for (int c = 0; c < CH; c++) e.d[c] = ref_out(c);
        exp_q.push_back(e);
        ready_from = cyc + N + 3;
      end else begin
        cnt++;
      end
    end
  endtask

  task automatic send(input logic [IW-1:0] d0, input logic [IW-1:0] d1);
    int tries;
    tries = 0;
    step(1'b1, d0, d1);
    while (!last_xfer && tries < 100) begin
      step(1'b1, d0, d1);
      tries++;
    end
    if (!last_xfer) begin
      checks++;
      failures++;
      $display("FAIL send_timeout cyc=%0d in_ready=%b", cyc, in_ready);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cyc < ready_from) && n < 500) begin
      step(1'b0, '0, '0);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout cyc=%0d pending=%0d", cyc, exp_q.size());
    end
    step(1'b0, '0, '0);
  endtask

  task automatic do_reset(input bit v);
    @(negedge clk);
    reset      = 1'b1;
    in_valid   = v;
    in_data[0] = IW'($urandom_range(30000, 1));
    in_data[1] = IW'($urandom_range(30000, 1));
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < TAPS; i++) hist[c][i] = 0;
    cnt = 0;
    exp_q.delete();
    ready_from = cyc + 1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL after_reset in_ready=%b out_valid=%b out_data=%h exp=1/0/0",
               in_ready, out_valid, out_data);
    end
  endtask

  task automatic impulse_coefs();
    for (int i = 0; i < TAPS; i++) coefficients[i] = CW'(1024 * i);
  endtask

  task automatic impulse_run();
    send(IW'(16384), '0);
    repeat (7) send('0, '0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_valid_unexpected cyc=%0d out_data=%h", cyc, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.due != cyc || out_data !== mon_e.d) begin
          failures++;
          $display("FAIL out_frame cyc=%0d got=%h exp=%h exp_cyc=%0d",
                   cyc, out_data, mon_e.d, mon_e.due);
        end
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
      checks++;
      failures++;
      $display("FAIL out_missing cyc=%0d exp=%h exp_cyc=%0d", cyc, exp_q[0].d, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    coefficients = '0;
    cnt          = 0;
    ready_from   = 0;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < TAPS; i++) hist[c][i] = 0;
    repeat (3) @(posedge clk);
    do_reset(1'b0);

    // impulse at two decimation phases; channel 1 stays silent
    impulse_coefs();
    impulse_run();
    send('0, '0);
    impulse_run();
    drain();

    // held-valid ramp
    for (int i = 0; i < 24; i++) send(IW'(i), IW'(-i));
    drain();

    // saturation both ways
    for (int i = 0; i < TAPS; i++) coefficients[i] = CW'(32767);
    repeat (16) send(IW'(32767), IW'(32767));
    repeat (16) send(IW'(-32768), IW'(-32768));
    drain();

    // rounding
    coefficients    = '0;
    coefficients[0] = CW'(-1);
    repeat (8) send(IW'(1), IW'(-1));
    drain();
    coefficients[0] = CW'(16384);
    repeat (8) send(IW'(3), IW'(-3));
    drain();

    // random coefficients, gaps and data
    for (int i = 0; i < TAPS; i++) coefficients[i] = CW'(int'($urandom_range(8191)) - 4096);
    for (int i = 0; i < 120; i++)
      step($urandom_range(3) != 0, IW'($urandom), IW'($urandom));
    drain();
    for (int i = 0; i < TAPS; i++) coefficients[i] = CW'($urandom);
    for (int i = 0; i < 40; i++) send(IW'($urandom), IW'($urandom));
    drain();

    // abort mid-pass, then reset colliding with a transfer, then clean impulse
    impulse_coefs();
    for (int i = 0; i < DECIM - cnt; i++) send(IW'($urandom), IW'($urandom));
    repeat (4) step(1'b0, '0, '0);
    do_reset(1'b0);
    repeat (3) step(1'b0, '0, '0);
    do_reset(1'b1);
    impulse_run();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
